// File: rtl/interval_timer.sv
// Programmable down-counting interval timer: prescaled tick, one-shot or
// auto-reload expiry, one-cycle expired pulse and sticky irq flag.
module interval_timer #(
   parameter int unsigned width          = 8,
   parameter int unsigned prescale_width = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      write,
   input  logic [width-1:0]          in,
   input  logic [prescale_width-1:0] prescale,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      auto_reload,
   input  logic                      irq_ack,
   output logic [width-1:0]          out,
   output logic                      running,
   output logic                      expired,
   output logic                      irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [width-1:0]          out_q, out_d;
   logic [width-1:0]          reload_q, reload_d;
   logic [prescale_width-1:0] pcnt_q, pcnt_d;
   logic                      expired_q, expired_d;
   logic                      irq_q, irq_d;
   logic                      tick;

   // prescale is compared live, so a lowered value below pcnt only
   // takes effect after pcnt wraps through zero
   assign tick = (pcnt_q == prescale);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         out_q     <= '0;
         reload_q  <= '0;
         pcnt_q    <= '0;
         expired_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         reload_q  <= reload_d;
         pcnt_q    <= pcnt_d;
         expired_q <= expired_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      reload_d  = reload_q;
      pcnt_d    = pcnt_q;
      expired_d = 1'b0;

      if (stop) begin
         state_d = IDLE;
         pcnt_d  = '0;
      end else if (write) begin
         reload_d = in;
         out_d    = in;
         pcnt_d   = '0;
         if (start) begin
            state_d = RUN;
         end else if (state_q == DONE) begin
            state_d = IDLE;
         end
      end else if (start && (state_q != RUN)) begin
         state_d = RUN;
         pcnt_d  = '0;
         if (state_q == DONE) begin
            out_d = reload_q;
         end
      end else if (state_q == RUN) begin
         if (tick) begin
            pcnt_d = '0;
            if (out_q != '0) begin
               out_d = out_q - 1'b1;
            end else begin
               expired_d = 1'b1;
               if (auto_reload) begin
                  out_d = reload_q;
               end else begin
                  state_d = DONE;
               end
            end
         end else begin
            pcnt_d = pcnt_q + 1'b1;
         end
      end

      // a new expiry outranks an acknowledge on the same edge
      irq_d = expired_d | (irq_q & ~irq_ack);
   end

   assign out     = out_q;
   assign running = (state_q == RUN);
   assign expired = expired_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed vector table, hand
// sequences for multi-cycle corners, and random stimulus against a model.
module tb_interval_timer;

   localparam int W  = 8;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          write;
   logic [W-1:0]  in;
   logic [PW-1:0] prescale;
   logic          start;
   logic          stop;
   logic          auto_reload;
   logic          irq_ack;
   logic [W-1:0]  out;
   logic          running;
   logic          expired;
   logic          irq;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_out, m_reload, m_pcnt;
   bit m_running, m_done, m_expired, m_irq;

   interval_timer #(.width(W), .prescale_width(PW)) dut (
      .clk(clk), .reset(reset), .write(write), .in(in), .prescale(prescale),
      .start(start), .stop(stop), .auto_reload(auto_reload), .irq_ack(irq_ack),
      .out(out), .running(running), .expired(expired), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit w; int din; int ps; bit st; bit sp; bit ar; bit ack;
      int eo; bit er; bit ee; bit ei;
   } vec_t;
   vec_t vecs[13];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out = 0; m_reload = 0; m_pcnt = 0;
      m_running = 0; m_done = 0; m_expired = 0; m_irq = 0;
   endtask

   // next state from the command rules, using the inputs seen at the edge
   task automatic model_edge();
      bit fire;
      fire = 0;
      if (stop) begin
         m_running = 0; m_done = 0; m_pcnt = 0;
      end else if (write) begin
         m_reload = int'(in); m_out = int'(in); m_pcnt = 0;
         m_running = m_running || start;
         m_done = 0;
      end else if (start && !m_running) begin
         if (m_done) m_out = m_reload;
         m_running = 1; m_done = 0; m_pcnt = 0;
      end else if (m_running) begin
         if (m_pcnt == int'(prescale)) begin
            m_pcnt = 0;
            if (m_out > 0) m_out = m_out - 1;
            else begin
               fire = 1;
               if (auto_reload) m_out = m_reload;
               else begin m_running = 0; m_done = 1; end
            end
         end else m_pcnt = (m_pcnt + 1) % (1 << PW);
      end
      m_irq = fire || (m_irq && !irq_ack);
      m_expired = fire;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".out"}, int'(out), m_out);
      check({tag, ".running"}, int'(running), int'(m_running));
      check({tag, ".expired"}, int'(expired), int'(m_expired));
      check({tag, ".irq"}, int'(irq), int'(m_irq));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (reset) model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic idle_inputs();
      write = 0; start = 0; stop = 0; irq_ack = 0;
   endtask

   initial begin
      int pulses, cyc;
      bit found;
      reset = 0; in = '0; prescale = '0; auto_reload = 0;
      idle_inputs();
      model_reset();

      // reset and idle
      repeat (3) step("reset");
      #3 reset = 1;
      repeat (4) step("idle");

      // directed vector table
      vecs[0]  = '{1, 3, 0, 0, 0, 0, 0,   3, 0, 0, 0};
      vecs[1]  = '{0, 0, 0, 1, 0, 0, 0,   3, 1, 0, 0};
      vecs[2]  = '{0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0};
      vecs[3]  = '{0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0};
      vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0};
      vecs[5]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1};
      vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1};
      vecs[7]  = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0};
      vecs[8]  = '{1, 5, 0, 1, 0, 0, 0,   5, 1, 0, 0};
      vecs[9]  = '{0, 0, 0, 1, 0, 0, 0,   4, 1, 0, 0};
      vecs[10] = '{0, 0, 0, 1, 1, 0, 0,   4, 0, 0, 0};
      vecs[11] = '{0, 0, 0, 1, 0, 0, 0,   4, 1, 0, 0};
      vecs[12] = '{0, 0, 0, 0, 1, 0, 0,   4, 0, 0, 0};
      for (int i = 0; i < 13; i++) begin
         write = vecs[i].w; in = W'(vecs[i].din); prescale = PW'(vecs[i].ps);
         start = vecs[i].st; stop = vecs[i].sp; auto_reload = vecs[i].ar;
         irq_ack = vecs[i].ack;
         step("vec");
         check($sformatf("vec%0d.out", i), int'(out), vecs[i].eo);
         check($sformatf("vec%0d.running", i), int'(running), int'(vecs[i].er));
         check($sformatf("vec%0d.expired", i), int'(expired), int'(vecs[i].ee));
         check($sformatf("vec%0d.irq", i), int'(irq), int'(vecs[i].ei));
      end
      idle_inputs();

      // prescaled periodic: three expiries in 36 cycles, reloading to 2
      write = 1; in = 8'd2; prescale = 8'd3; auto_reload = 1; start = 1;
      step("periodic_load");
      idle_inputs();
      pulses = 0;
      for (int i = 0; i < 36; i++) begin
         step("periodic");
         if (expired) begin
            pulses++;
            check("periodic_reload", int'(out), 2);
         end
      end
      check("periodic_pulses", pulses, 3);
      irq_ack = 1; stop = 1;
      step("periodic_stop");
      idle_inputs();

      // zero interval, every cycle expires; ack loses to a same-edge set
      write = 1; in = 8'd0; prescale = 8'd0; auto_reload = 1; start = 1;
      step("zero_load");
      idle_inputs();
      irq_ack = 1;
      for (int i = 0; i < 4; i++) begin
         step("zero_run");
         check("zero_expired", int'(expired), 1);
         check("zero_irq_held", int'(irq), 1);
         check("zero_out", int'(out), 0);
      end
      irq_ack = 0; auto_reload = 0;
      step("zero_oneshot");
      check("zero_done_running", int'(running), 0);
      check("zero_done_expired", int'(expired), 1);
      irq_ack = 1;
      step("zero_after");
      check("zero_after_expired", int'(expired), 0);
      idle_inputs();

      // asynchronous reset mid-count
      write = 1; in = 8'd7; prescale = 8'd5; start = 1;
      step("mid_load");
      idle_inputs();
      repeat (2) step("mid_run");
      check("mid_pre_out", int'(out), 7);
      #2 reset = 0;
      #1;
      model_reset();
      check_model("async_reset");
      #3 reset = 1;
      prescale = 8'd2; start = 1;
      step("post_start");
      start = 0;
      found = 0; cyc = 0;
      for (int i = 1; i <= 10 && !found; i++) begin
         step("post_run");
         if (expired) begin found = 1; cyc = i; end
      end
      check("post_found", int'(found), 1);
      check("post_latency", cyc, 3);
      stop = 1; irq_ack = 1;
      step("post_stop");
      idle_inputs();

      // randomized traffic against the model
      prescale = 8'd1;
      for (int i = 0; i < 3000; i++) begin
         write = ($urandom % 10) == 0;
         in = W'($urandom % 8);
         start = ($urandom % 6) == 0;
         stop = ($urandom % 25) == 0;
         auto_reload = ($urandom % 3) != 0;
         irq_ack = ($urandom % 8) == 0;
         if (($urandom % 50) == 0) prescale = PW'($urandom % 4);
         if (($urandom % 600) == 0) prescale = PW'($urandom % 256);
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
